// File: rtl/rob_multiway_pkg.sv
// Shared ROB types: dispatch/CDB packets, stored entry, index and wrap-bit pointer.
`ifndef ROB_SIZE
`define ROB_SIZE 32
`endif

package rob_multiway_pkg;

    localparam int unsigned ROB_SIZE  = `ROB_SIZE;
    localparam int unsigned ROB_IDX_W = $clog2(ROB_SIZE);
    localparam int unsigned REG_W     = 5;
    localparam int unsigned PC_W      = 32;

    typedef logic [ROB_IDX_W-1:0] ROB_IDX;

    typedef struct packed {
        logic   wrap;
        ROB_IDX idx;
    } ROB_PTR;

    typedef struct packed {
        logic             valid;
        logic             is_store;
        logic             halt;
        logic [REG_W-1:0] dest_reg;
        logic [PC_W-1:0]  pc;
    } ROB_PACKET;

    typedef struct packed {
        logic             complete;
        logic             is_store;
        logic             halt;
        logic [REG_W-1:0] dest_reg;
        logic [PC_W-1:0]  pc;
    } ROB_ENTRY;

    typedef struct packed {
        logic   valid;
        ROB_IDX rob_idx;
        logic   squash_enable;
    } CDB_PACKET;

endpackage

// File: rtl/rob_retire_select.sv
// In-order retire group selection over the RET_W entries starting at head.
module rob_retire_select #(
    parameter int unsigned RET_W = 2,
    parameter int unsigned CNT_W = 6
) (
    input  logic [RET_W-1:0] head_complete,
    input  logic [RET_W-1:0] head_store,
    input  logic [RET_W-1:0] head_halt,
    input  logic [CNT_W-1:0] count,
    input  logic             store_stall,
    output logic [RET_W-1:0] retire_valid,
    output logic             store_retire
);

    // A lane retires only while every older lane did; a store or halt closes the group.
    always_comb begin
        logic go;
        retire_valid = '0;
        store_retire = 1'b0;
        go           = 1'b1;
        for (int k = 0; k < RET_W; k++) begin
            if (go && (CNT_W'(k) < count) && head_complete[k]
                    && !(head_store[k] && store_stall)) begin
                retire_valid[k] = 1'b1;
                if (head_store[k]) begin
                    store_retire = 1'b1;
                    go           = 1'b0;
                end
                if (head_halt[k]) begin
                    go = 1'b0;
                end
            end else begin
                go = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_multiway.sv
// N-wide reorder buffer: multi-lane dispatch, CDB completion, in-order retire, branch squash.
module rob_multiway
    import rob_multiway_pkg::*;
#(
    parameter int unsigned ROB_DEPTH = 32,
    parameter int unsigned DISP_W    = 2,
    parameter int unsigned RET_W     = 2,
    parameter int unsigned CDB_W     = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        dcache_store_stall,
    input  ROB_PACKET [DISP_W-1:0]      disp_in,
    input  CDB_PACKET [CDB_W-1:0]       cdb_in,
    output logic [$clog2(ROB_DEPTH):0]  disp_free,
    output ROB_IDX                      disp_base_idx,
    output logic [RET_W-1:0]            retire_valid,
    output ROB_ENTRY [RET_W-1:0]        retire_entry,
    output logic                        rob2sq_retire_en,
    output ROB_IDX                      head_ptr_out,
    output ROB_IDX                      tail_ptr_out,
    output logic [$clog2(ROB_DEPTH):0]  count,
    output logic                        full,
    output logic                        empty
);

    localparam int unsigned IDX_W = $clog2(ROB_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [PTR_W-1:0] ptr_t;

    ROB_ENTRY             entries_q [ROB_DEPTH];
    ptr_t                 head_q, tail_q, head_d, tail_d;
    ptr_t                 occ, n_disp, n_ret;
    idx_t                 head_idx, tail_idx;
    ROB_ENTRY [RET_W-1:0] win;
    logic [RET_W-1:0]     win_complete, win_store, win_halt;
    idx_t                 cdb_idx  [CDB_W];
    idx_t                 cdb_dist [CDB_W];
    logic [CDB_W-1:0]     cdb_hit;
    logic                 sq_hit;
    idx_t                 sq_dist;
    logic                 prefix_ok, disp_go;

    assign head_idx      = head_q[IDX_W-1:0];
    assign tail_idx      = tail_q[IDX_W-1:0];
    assign occ           = tail_q - head_q;
    assign count         = occ;
    assign full          = (occ == PTR_W'(ROB_DEPTH));
    assign empty         = (occ == '0);
    assign disp_free     = PTR_W'(ROB_DEPTH) - occ;
    assign disp_base_idx = ROB_IDX'(tail_idx);
    assign head_ptr_out  = ROB_IDX'(head_idx);
    assign tail_ptr_out  = ROB_IDX'(tail_idx);
    assign retire_entry  = win;

    always_comb begin
        for (int k = 0; k < RET_W; k++) begin
            win[k]          = entries_q[idx_t'(head_idx + idx_t'(k))];
            win_complete[k] = win[k].complete;
            win_store[k]    = win[k].is_store;
            win_halt[k]     = win[k].halt;
        end
    end

    rob_retire_select #(
        .RET_W (RET_W),
        .CNT_W (PTR_W)
    ) u_retire_select (
        .head_complete (win_complete),
        .head_store    (win_store),
        .head_halt     (win_halt),
        .count         (occ),
        .store_stall   (dcache_store_stall),
        .retire_valid  (retire_valid),
        .store_retire  (rob2sq_retire_en)
    );

    // Completion hits inside [head, tail); the oldest squashing hit wins.
    always_comb begin
        cdb_hit = '0;
        sq_hit  = 1'b0;
        sq_dist = '0;
        for (int i = 0; i < CDB_W; i++) begin
            cdb_idx[i]  = cdb_in[i].rob_idx[IDX_W-1:0];
            cdb_dist[i] = cdb_idx[i] - head_idx;
            if (cdb_in[i].valid
                    && ({1'b0, cdb_in[i].rob_idx} < (ROB_IDX_W+1)'(ROB_DEPTH))
                    && (PTR_W'(cdb_dist[i]) < occ)) begin
                cdb_hit[i] = 1'b1;
                if (cdb_in[i].squash_enable && (!sq_hit || (cdb_dist[i] < sq_dist))) begin
                    sq_hit  = 1'b1;
                    sq_dist = cdb_dist[i];
                end
            end
        end
    end

    always_comb begin
        n_disp    = '0;
        prefix_ok = 1'b1;
        for (int i = 0; i < DISP_W; i++) begin
            if (disp_in[i].valid) begin
                n_disp = n_disp + PTR_W'(1);
                if (i > 0 && !disp_in[i-1].valid) begin
                    prefix_ok = 1'b0;
                end
            end
        end
        n_ret = '0;
        for (int k = 0; k < RET_W; k++) begin
            n_ret = n_ret + PTR_W'(retire_valid[k]);
        end
    end

    // Dispatch is all-or-nothing and is dropped whenever a squash lands.
    assign disp_go = !sq_hit && (n_disp != '0) && (n_disp <= disp_free);

    always_comb begin
        head_d = head_q + n_ret;
        tail_d = tail_q;
        if (sq_hit) begin
            tail_d = head_q + PTR_W'(sq_dist) + PTR_W'(1);
        end else if (disp_go) begin
            tail_d = tail_q + n_disp;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
            for (int e = 0; e < ROB_DEPTH; e++) begin
                entries_q[e] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            for (int i = 0; i < CDB_W; i++) begin
                if (cdb_hit[i]) begin
                    entries_q[cdb_idx[i]].complete <= 1'b1;
                end
            end
            if (disp_go) begin
                for (int i = 0; i < DISP_W; i++) begin
                    if (disp_in[i].valid) begin
                        entries_q[idx_t'(tail_idx + idx_t'(i))] <= '{
                            complete: disp_in[i].halt,
                            is_store: disp_in[i].is_store,
                            halt:     disp_in[i].halt,
                            dest_reg: disp_in[i].dest_reg,
                            pc:       disp_in[i].pc
                        };
                    end
                end
            end
        end
    end

    dispatch_prefix_a: assert property (@(posedge clock) disable iff (!reset) prefix_ok);

endmodule

// File: tb/tb_rob_multiway.sv
// Bench for rob_multiway: queue-based ROB model plus retire-stream scoreboard.
module tb_rob_multiway;
    import rob_multiway_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned DW    = 2;
    localparam int unsigned RW    = 2;
    localparam int unsigned CW    = 2;
    localparam int unsigned CNTW  = $clog2(DEPTH) + 1;

    typedef ROB_PACKET [DW-1:0] disp_vec_t;
    typedef CDB_PACKET [CW-1:0] cdb_vec_t;
    typedef struct {
        bit          cmp;
        bit          st;
        bit          hlt;
        logic [31:0] pc;
    } m_ent_t;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 dcache_store_stall = 1'b0;
    disp_vec_t            disp_in = '0;
    cdb_vec_t             cdb_in = '0;
    logic [CNTW-1:0]      disp_free, count;
    ROB_IDX               disp_base_idx, head_ptr_out, tail_ptr_out;
    logic [RW-1:0]        retire_valid;
    ROB_ENTRY [RW-1:0]    retire_entry;
    logic                 rob2sq_retire_en, full, empty;

    m_ent_t      m_q[$];
    m_ent_t      sb_q[$];
    int unsigned m_head = 0;
    int          tests = 0;
    int          fails = 0;
    int unsigned pc_ctr = 1;

    rob_multiway #(
        .ROB_DEPTH (DEPTH),
        .DISP_W    (DW),
        .RET_W     (RW),
        .CDB_W     (CW)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .dcache_store_stall (dcache_store_stall),
        .disp_in            (disp_in),
        .cdb_in             (cdb_in),
        .disp_free          (disp_free),
        .disp_base_idx      (disp_base_idx),
        .retire_valid       (retire_valid),
        .retire_entry       (retire_entry),
        .rob2sq_retire_en   (rob2sq_retire_en),
        .head_ptr_out       (head_ptr_out),
        .tail_ptr_out       (tail_ptr_out),
        .count              (count),
        .full               (full),
        .empty              (empty)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic ROB_PACKET pkt(input bit st, input bit h);
        ROB_PACKET p;
        p.valid    = 1'b1;
        p.is_store = st;
        p.halt     = h;
        p.dest_reg = 5'($urandom);
        p.pc       = pc_ctr;
        pc_ctr++;
        return p;
    endfunction

    function automatic disp_vec_t dv(input int n, input bit st0, input bit st1);
        disp_vec_t d = '0;
        if (n > 0) d[0] = pkt(st0, 1'b0);
        if (n > 1) d[1] = pkt(st1, 1'b0);
        return d;
    endfunction

    function automatic cdb_vec_t cv(input int n, input int i0, input int i1, input bit s0, input bit s1);
        cdb_vec_t c = '0;
        if (n > 0) begin c[0].valid = 1'b1; c[0].rob_idx = ROB_IDX'(i0); c[0].squash_enable = s0; end
        if (n > 1) begin c[1].valid = 1'b1; c[1].rob_idx = ROB_IDX'(i1); c[1].squash_enable = s1; end
        return c;
    endfunction

    // One cycle: drive at negedge, check outputs against the model, then advance the model.
    task automatic step(input bit stall, input disp_vec_t d, input cdb_vec_t c);
        int cnt, n_ret, n_disp, sq_d, dd;
        bit stop, has_st;
        m_ent_t e;
        @(negedge clock);
        dcache_store_stall = stall;
        disp_in = d;
        cdb_in = c;
        #1;
        cnt = m_q.size();
        chk("count", count, cnt);
        chk("empty", empty, cnt == 0);
        chk("full", full, cnt == DEPTH);
        chk("disp_free", disp_free, DEPTH - cnt);
        chk("head", head_ptr_out, m_head);
        chk("tail", tail_ptr_out, (m_head + cnt) % DEPTH);
        chk("disp_base", disp_base_idx, (m_head + cnt) % DEPTH);
        n_ret = 0; stop = 0; has_st = 0;
        for (int k = 0; k < RW && !stop; k++) begin
            if (k < cnt && m_q[k].cmp && !(m_q[k].st && stall)) begin
                n_ret++;
                if (m_q[k].st) has_st = 1;
                if (m_q[k].st || m_q[k].hlt) stop = 1;
            end else begin
                stop = 1;
            end
        end
        chk("retire_valid", retire_valid, (1 << n_ret) - 1);
        chk("rob2sq_retire_en", rob2sq_retire_en, has_st);
        sq_d = -1;
        for (int i = 0; i < CW; i++) begin
            if (c[i].valid) begin
                dd = (int'(c[i].rob_idx) + DEPTH - int'(m_head)) % DEPTH;
                if (dd < cnt) begin
                    m_q[dd].cmp = 1;
                    if (c[i].squash_enable && (sq_d < 0 || dd < sq_d)) sq_d = dd;
                end
            end
        end
        if (sq_d >= 0) begin
            while (m_q.size() > sq_d + 1) begin
                void'(m_q.pop_back());
                void'(sb_q.pop_back());
            end
        end
        n_disp = 0;
        for (int i = 0; i < DW; i++) if (d[i].valid) n_disp++;
        if (sq_d < 0 && n_disp <= DEPTH - cnt) begin
            for (int i = 0; i < n_disp; i++) begin
                e.cmp = d[i].halt; e.st = d[i].is_store; e.hlt = d[i].halt; e.pc = d[i].pc;
                m_q.push_back(e);
                sb_q.push_back(e);
            end
        end
        for (int k = 0; k < n_ret; k++) void'(m_q.pop_front());
        m_head = (m_head + n_ret) % DEPTH;
    endtask

    task automatic rand_cycle();
        disp_vec_t d = '0;
        cdb_vec_t c = '0;
        int nd, dd;
        nd = $urandom_range(0, DW);
        for (int i = 0; i < nd; i++) begin
            d[i] = pkt($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
        end
        for (int i = 0; i < CW; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                c[i].valid = 1'b1;
                c[i].rob_idx = ROB_IDX'($urandom_range(0, DEPTH - 1));
                dd = (int'(c[i].rob_idx) + DEPTH - int'(m_head)) % DEPTH;
                if ($urandom_range(0, 9) == 0 && (dd >= m_q.size() || !m_q[dd].cmp))
                    c[i].squash_enable = 1'b1;
            end
        end
        step($urandom_range(0, 3) == 0, d, c);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_disp_free"}, disp_free, DEPTH);
        chk({tag, "_head"}, head_ptr_out, 0);
        chk({tag, "_tail"}, tail_ptr_out, 0);
        chk({tag, "_retire_valid"}, retire_valid, 0);
        chk({tag, "_rob2sq"}, rob2sq_retire_en, 0);
    endtask

    // Retire monitor: every presented lane must match the next expected instruction.
    initial begin
        m_ent_t x;
        forever begin
            @(negedge clock);
            #2;
            for (int k = 0; k < RW; k++) begin
                if (retire_valid[k] === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL retire_unexpected: lane %0d pc %0d, expected no retire", k, retire_entry[k].pc);
                    end else begin
                        x = sb_q.pop_front();
                        chk("retire_pc", retire_entry[k].pc, x.pc);
                        chk("retire_store", retire_entry[k].is_store, x.st);
                        chk("retire_halt", retire_entry[k].halt, x.hlt);
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1;
        check_reset_values("reset");
        reset = 1'b1;

        // Fill to full, then an extra dispatch is refused.
        repeat (4) step(0, dv(2, 0, 0), cv(0, 0, 0, 0, 0));
        step(0, dv(2, 0, 0), cv(0, 0, 0, 0, 0));
        // Burst retire.
        step(0, dv(0, 0, 0), cv(2, 0, 1, 0, 0));
        step(0, dv(0, 0, 0), cv(2, 2, 3, 0, 0));
        step(0, dv(0, 0, 0), cv(0, 0, 0, 0, 0));
        step(0, dv(0, 0, 0), cv(0, 0, 0, 0, 0));
        // Gap: 4 and 6 complete, 5 pending.
        step(0, dv(0, 0, 0), cv(2, 4, 6, 0, 0));
        step(0, dv(0, 0, 0), cv(0, 0, 0, 0, 0));
        step(0, dv(0, 0, 0), cv(1, 5, 0, 0, 0));
        step(0, dv(0, 0, 0), cv(1, 7, 0, 0, 0));
        step(0, dv(0, 0, 0), cv(0, 0, 0, 0, 0));
        step(0, dv(0, 0, 0), cv(0, 0, 0, 0, 0));
        // Store gating by dcache stall.
        step(0, dv(2, 1, 0), cv(0, 0, 0, 0, 0));
        step(0, dv(0, 0, 0), cv(2, 0, 1, 0, 0));
        step(1, dv(0, 0, 0), cv(0, 0, 0, 0, 0));
        step(1, dv(0, 0, 0), cv(0, 0, 0, 0, 0));
        step(0, dv(0, 0, 0), cv(0, 0, 0, 0, 0));
        step(0, dv(0, 0, 0), cv(0, 0, 0, 0, 0));
        // Move head to 6, build wrapped window 6..2, then two squashes plus dispatch.
        step(0, dv(2, 0, 0), cv(0, 0, 0, 0, 0));
        step(0, dv(2, 0, 0), cv(2, 2, 3, 0, 0));
        step(0, dv(0, 0, 0), cv(2, 4, 5, 0, 0));
        step(0, dv(0, 0, 0), cv(0, 0, 0, 0, 0));
        step(0, dv(2, 0, 0), cv(0, 0, 0, 0, 0));
        step(0, dv(2, 0, 0), cv(0, 0, 0, 0, 0));
        step(0, dv(1, 0, 0), cv(0, 0, 0, 0, 0));
        step(0, dv(2, 0, 0), cv(2, 1, 7, 1, 1));
        step(0, dv(0, 0, 0), cv(0, 0, 0, 0, 0));
        chk("squash_tail", tail_ptr_out, 0);
        chk("squash_count", count, 2);
        step(0, dv(0, 0, 0), cv(1, 6, 0, 0, 0));
        step(0, dv(0, 0, 0), cv(0, 0, 0, 0, 0));
        // Async reset with five entries in flight.
        step(0, dv(2, 0, 0), cv(0, 0, 0, 0, 0));
        step(0, dv(2, 0, 0), cv(0, 0, 0, 0, 0));
        step(0, dv(1, 0, 0), cv(0, 0, 0, 0, 0));
        step(0, dv(0, 0, 0), cv(0, 0, 0, 0, 0));
        disp_in = '0;
        cdb_in = '0;
        @(negedge clock);
        #3;
        chk("pre_reset_count", count, 5);
        reset = 1'b0;
        #1;
        check_reset_values("async_reset");
        m_q.delete();
        sb_q.delete();
        m_head = 0;
        @(negedge clock);
        reset = 1'b1;

        repeat (3000) rand_cycle();
        repeat (12) step(0, dv(0, 0, 0), cv(2, (m_head) % DEPTH, (m_head + 1) % DEPTH, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
